// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter
//
// Round-robin arbiter for two requesters (A and B). It drives the select line of the
// 2:1 mux that sits directly downstream. Every grant is followed by a one-cycle dead
// gap, so the mux select never moves while a grant is live.
//
// Requests are registered on entry. A request that is sampled high on edge N produces
// a grant after edge N+1. All outputs except busy_out come straight from flops.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   defined   - a grant is force-released after MAX_HOLD cycles while the other side
//               waits. timeout_out pulses for the following gap cycle.
//   undefined - a grant lasts as long as its request stays high. timeout_out is 0.
//
// Parameters:
//   MAX_HOLD     max consecutive grant cycles under contention (>= 2, timeout build only)
//
// Ports:
//   clk_in       clock, rising edge
//   rst_n_in     asynchronous active-low reset
//   req_a_in     requester A wants the path (level, held until done)
//   req_b_in     requester B wants the path (level, held until done)
//   grant_a_out  A owns the path (registered)
//   grant_b_out  B owns the path (registered)
//   sel_out      mux select, 0 = A, 1 = B (registered)
//   busy_out     grant_a_out | grant_b_out
//   timeout_out  one-cycle pulse on a forced release

module mux_sel_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic req_a_in,
    input  logic req_b_in,
    output logic grant_a_out,
    output logic grant_b_out,
    output logic sel_out,
    output logic busy_out,
    output logic timeout_out
);

    if (MAX_HOLD < 2) begin : g_bad_max_hold
        $error("mux_sel_arbiter: MAX_HOLD must be at least 2");
    end

    typedef enum logic [1:0] {
        StIdle,
        StGntA,
        StGntB,
        StGap
    } state_e;

    state_e state_q;
    logic   req_a_q;
    logic   req_b_q;
    logic   last_b_q;     // 1 when the most recent grant went to B
    logic   grant_a_q;
    logic   grant_b_q;
    logic   sel_q;
    logic   timeout_q;
    logic   pick_b;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(MAX_HOLD + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_HOLD);
    localparam logic [CntW-1:0] RelCnt = CntW'(MAX_HOLD - 1);

    logic [CntW-1:0] hold_cnt_q;
    logic            hold_expired;

    // hold_cnt_q is (grant cycles so far - 1). It reaches RelCnt in the MAX_HOLD-th cycle.
    // The >= also releases a saturated holder as soon as contention appears.
    assign hold_expired = (hold_cnt_q >= RelCnt);
`endif

    // Both requesting: serve the side that did not get the last grant.
    assign pick_b = req_b_q && (!req_a_q || !last_b_q);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= StIdle;
            req_a_q    <= 1'b0;
            req_b_q    <= 1'b0;
            last_b_q   <= 1'b1;   // A wins the first tie
            grant_a_q  <= 1'b0;
            grant_b_q  <= 1'b0;
            sel_q      <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            req_a_q   <= req_a_in;
            req_b_q   <= req_b_in;
            timeout_q <= 1'b0;
            unique case (state_q)
                StIdle, StGap: begin
                    if (req_a_q || req_b_q) begin
                        if (pick_b) begin
                            state_q   <= StGntB;
                            grant_b_q <= 1'b1;
                            sel_q     <= 1'b1;
                            last_b_q  <= 1'b1;
                        end else begin
                            state_q   <= StGntA;
                            grant_a_q <= 1'b1;
                            sel_q     <= 1'b0;
                            last_b_q  <= 1'b0;
                        end
`ifdef ARB_TIMEOUT_EN
                        hold_cnt_q <= '0;
`endif
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StGntA: begin
                    if (!req_a_q) begin
                        state_q   <= StGap;
                        grant_a_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    end else if (req_b_q && hold_expired) begin
                        state_q   <= StGap;
                        grant_a_q <= 1'b0;
                        timeout_q <= 1'b1;
                    end else if (hold_cnt_q != MaxCnt) begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
`endif
                    end
                end
                StGntB: begin
                    if (!req_b_q) begin
                        state_q   <= StGap;
                        grant_b_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    end else if (req_a_q && hold_expired) begin
                        state_q   <= StGap;
                        grant_b_q <= 1'b0;
                        timeout_q <= 1'b1;
                    end else if (hold_cnt_q != MaxCnt) begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
`endif
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    grant_a_q <= 1'b0;
                    grant_b_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant_a_out = grant_a_q;
    assign grant_b_out = grant_b_q;
    assign sel_out     = sel_q;
    assign busy_out    = grant_a_q | grant_b_q;
    assign timeout_out = timeout_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter. Directed scenarios are followed by random
// traffic. A cycle-level ownership model produces the expected values. It is built
// with or without ARB_TIMEOUT_EN.

module tb_mux_sel_arbiter;

    localparam int unsigned MaxHold = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic req_a;
    logic req_b;
    logic grant_a;
    logic grant_b;
    logic sel;
    logic busy;
    logic timeout;

    int checks = 0;
    int failures = 0;

    // Model state: owner 0 = nobody, 1 = A, 2 = B
    int   m_owner;
    int   m_last;
    int   m_held;     // grant cycles so far for the current owner
    logic m_sel;
    logic m_tmo;
    logic m_pa;       // requests captured on the previous edge
    logic m_pb;

    mux_sel_arbiter #(
        .MAX_HOLD (MaxHold)
    ) dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .req_a_in    (req_a),
        .req_b_in    (req_b),
        .grant_a_out (grant_a),
        .grant_b_out (grant_b),
        .sel_out     (sel),
        .busy_out    (busy),
        .timeout_out (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_last  = 2;
        m_held  = 0;
        m_sel   = 1'b0;
        m_tmo   = 1'b0;
        m_pa    = 1'b0;
        m_pb    = 1'b0;
    endtask

    // A decision at an edge uses the requests captured one edge earlier.
    task automatic model_step(input logic ra, input logic rb);
        logic mine;
        logic other;
        m_tmo = 1'b0;
        if (m_owner == 0) begin
            if (m_pa || m_pb) begin
                if (m_pa && m_pb) m_owner = (m_last == 1) ? 2 : 1;
                else              m_owner = m_pa ? 1 : 2;
                m_last = m_owner;
                m_held = 1;
                m_sel  = (m_owner == 2);
            end
        end else begin
            mine  = (m_owner == 1) ? m_pa : m_pb;
            other = (m_owner == 1) ? m_pb : m_pa;
            if (!mine) begin
                m_owner = 0;
            end else if (TimeoutEn && other && m_held >= int'(MaxHold)) begin
                m_owner = 0;
                m_tmo   = 1'b1;
            end else begin
                m_held++;
            end
        end
        m_pa = ra;
        m_pb = rb;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".grant_a"}, grant_a, m_owner == 1);
        chk({tag, ".grant_b"}, grant_b, m_owner == 2);
        chk({tag, ".sel"}, sel, m_sel);
        chk({tag, ".busy"}, busy, m_owner != 0);
        chk({tag, ".timeout"}, timeout, m_tmo);
        chk({tag, ".mutex"}, grant_a & grant_b, 1'b0);
    endtask

    // Drive requests, let one edge pass, update the model, and check on the falling edge.
    task automatic cycle(input string tag, input logic ra, input logic rb);
        req_a = ra;
        req_b = rb;
        @(posedge clk);
        if (rst_n) model_step(ra, rb);
        else       model_reset();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) cycle("reset", 1'($urandom), 1'($urandom));
        rst_n = 1'b1;
    endtask

    initial begin
        int run_a;
        int max_run_a;
        int tmo_cnt;
        logic ra;
        logic rb;

        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        model_reset();

        // Reset with random requests, then idle after release.
        do_reset(4);
        for (int i = 0; i < 5; i++) cycle("idle", 1'b0, 1'b0);

        // Single request from A, then release into the gap and idle.
        for (int i = 0; i < 7; i++) cycle("single", 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle("single_rel", 1'b0, 1'b0);

        // A tie after reset goes to A. When A drops, B follows after one gap cycle.
        do_reset(2);
        for (int i = 0; i < 4; i++) cycle("tie", 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cycle("tie_b", 1'b0, 1'b1);

        // Async reset between edges while B holds the grant.
        chk("pre_async.grant_b", grant_b, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async.grant_a", grant_a, 1'b0);
        chk("async.grant_b", grant_b, 1'b0);
        chk("async.busy", busy, 1'b0);
        chk("async.sel", sel, 1'b0);
        model_reset();
        @(negedge clk);
        cycle("async_hold", 1'b1, 1'b1);
        rst_n = 1'b1;

        // Continuous contention: A wins first, and the timeout build alternates.
        run_a = 0;
        max_run_a = 0;
        tmo_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            cycle("contend", 1'b1, 1'b1);
            run_a = grant_a ? run_a + 1 : 0;
            if (run_a > max_run_a) max_run_a = run_a;
            if (timeout) tmo_cnt++;
        end
        if (TimeoutEn) begin
            chk_int("contend.max_run_a", max_run_a, int'(MaxHold));
            chk("contend.some_timeout", tmo_cnt > 0, 1'b1);
        end else begin
            chk("contend.long_run_a", max_run_a >= 50, 1'b1);
            chk_int("contend.timeouts", tmo_cnt, 0);
        end

        // A drops for one cycle and then re-requests while B stays idle.
        for (int i = 0; i < 4; i++) cycle("quiet", 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle("rereq_a", 1'b1, 1'b0);
        cycle("rereq_drop", 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle("rereq_again", 1'b1, 1'b0);

        // Random traffic where requests stay asserted for a while.
        ra = 1'b0;
        rb = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) ra = ~ra;
            if ($urandom_range(3) == 0) rb = ~rb;
            cycle("random", ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
